// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave in front of a word-organised synchronous RAM with byte-write enables.
// Read and write channels run independent FSMs, each with one transaction in flight.
//
//   state  | meaning
//   W_IDLE | collecting AW and W in either order; commit on the first edge both are held
//   W_RESP | bvalid/bresp held until the initiator takes the response
//   R_IDLE | arready high, waiting for a read address
//   R_READ | stage 0 samples the RAM, stage 1 loads rdata/rresp and raises rvalid
//   R_RESP | rvalid/rdata/rresp held until the initiator takes the data
module axi_lite_ram_slave #(
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready
);

    localparam int          HI          = DEPTH_LOG2 + 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;
    logic                  run;
    logic                  aw_got, w_got, aw_ok, ar_ok, rd_stage;
    logic [DEPTH_LOG2-1:0] aw_idx, ar_idx;
    logic [31:0]           w_data, ram_q;
    logic [3:0]            w_strb;
    logic                  commit, rd_en;
    logic                  unused_bits;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    function automatic logic in_range(input logic [31:0] a);
        return a[31:HI] == BASE_ADDR[31:HI];
    endfunction

    // run keeps every ready low while reset is held and for the first edge after it
    assign axi_awready = run && (w_state == W_IDLE) && !aw_got;
    assign axi_wready  = run && (w_state == W_IDLE) && !w_got;
    assign axi_arready = run && (r_state == R_IDLE);
    assign commit      = (w_state == W_IDLE) && aw_got && w_got;
    assign rd_en       = (r_state == R_READ) && !rd_stage;
    assign unused_bits = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state    <= W_IDLE;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            aw_idx     <= '0;
            aw_ok      <= 1'b0;
            w_data     <= '0;
            w_strb     <= '0;
            axi_bvalid <= 1'b0;
            axi_bresp  <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (axi_awvalid && axi_awready) begin
                        aw_got <= 1'b1;
                        aw_idx <= axi_awaddr[HI-1:2];
                        aw_ok  <= in_range(axi_awaddr);
                    end
                    if (axi_wvalid && axi_wready) begin
                        w_got  <= 1'b1;
                        w_data <= axi_wdata;
                        w_strb <= axi_wstrb;
                    end
                    if (commit) begin
                        axi_bvalid <= 1'b1;
                        axi_bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
                        w_state    <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        axi_bvalid <= 1'b0;
                        aw_got     <= 1'b0;
                        w_got      <= 1'b0;
                        w_state    <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= R_IDLE;
            ar_idx     <= '0;
            ar_ok      <= 1'b0;
            rd_stage   <= 1'b0;
            axi_rvalid <= 1'b0;
            axi_rresp  <= RESP_OKAY;
            axi_rdata  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi_arvalid && axi_arready) begin
                        ar_idx   <= axi_araddr[HI-1:2];
                        ar_ok    <= in_range(axi_araddr);
                        rd_stage <= 1'b0;
                        r_state  <= R_READ;
                    end
                end
                R_READ: begin
                    if (!rd_stage) begin
                        rd_stage <= 1'b1;
                    end else begin
                        axi_rvalid <= 1'b1;
                        axi_rdata  <= ar_ok ? ram_q : 32'h0;
                        axi_rresp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                        r_state    <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (axi_rready) begin
                        axi_rvalid <= 1'b0;
                        r_state    <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Single-port-pair BRAM; nonblocking read gives read-first on a same-word collision
    always_ff @(posedge clk) begin
        if (commit && aw_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) begin
                    mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            ram_q <= mem[ar_idx];
        end
    end

endmodule
